// File: rtl/jtsdram_shuffle_seq.sv
// rtl/jtsdram_shuffle_seq.sv - write/verify test sequencer for the jtsdram_shuffle address scrambler
module jtsdram_shuffle_seq #(
   parameter logic [4:0]  LAST_KEY = 5'd31,
   parameter logic [15:0] SEED     = 16'h5AC3,
   // top logical address swept in each verify pass (full 22-bit space by default)
   parameter logic [21:0] LOG_LAST = 22'h3FFFFF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic [21:0] addr_last,
   output logic [4:0]  key,
   output logic [21:0] addr_in,
   output logic        prog_en,
   output logic [21:0] prog_addr,
   output logic [15:0] ref_in,
   input  logic [21:0] shf_addr,
   input  logic [15:0] ref_shf,
   output logic        mem_req,
   output logic        mem_we,
   output logic [21:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic        mem_ack,
   input  logic        mem_dok,
   input  logic [15:0] mem_dout,
   output logic        busy,
   output logic        done,
   output logic [15:0] err_cnt,
   output logic [21:0] err_addr,
   output logic [4:0]  pass_cnt
);

   typedef enum logic [2:0] {IDLE, PROG, VSET, VREQ, VWAIT, VNEXT, DONE} state_t;

   state_t      state;
   logic [21:0] lcnt;      // logical address being verified
   logic [21:0] pcnt;      // physical address being written
   logic [21:0] last;      // addr_last captured at start
   logic        dok_seen;  // read data arrived together with the ack
   logic [15:0] rd_data;   // read data held for that case
   logic [15:0] got;
   logic        mismatch;

   function automatic logic [15:0] pattern(input logic [21:0] a);
      return a[15:0] ^ {a[21:16], 10'd0} ^ SEED;
   endfunction

   // read data under test: early data captured in VREQ, otherwise the live bus
   always_comb begin
      got      = dok_seen ? rd_data : mem_dout;
      mismatch = (got != ref_shf);
   end

   // sequencer FSM; every output is registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lcnt      <= '0;
         pcnt      <= '0;
         last      <= '0;
         dok_seen  <= 1'b0;
         rd_data   <= '0;
         key       <= '0;
         addr_in   <= '0;
         prog_en   <= 1'b0;
         prog_addr <= '0;
         ref_in    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_cnt   <= '0;
         err_addr  <= '0;
         pass_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  err_cnt   <= '0;
                  err_addr  <= '0;
                  pass_cnt  <= '0;
                  key       <= '0;
                  pcnt      <= '0;
                  last      <= addr_last;
                  busy      <= 1'b1;
                  prog_en   <= 1'b1;
                  prog_addr <= '0;
                  ref_in    <= pattern(22'd0);
                  state     <= PROG;
               end
            end
            PROG: begin
               if (!mem_req) begin
                  // prog_addr has been on the shuffle for a cycle, so ref_shf is the write data
                  if (stop) begin
                     state <= DONE;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b1;
                     mem_addr <= pcnt;
                     mem_din  <= ref_shf;
                  end
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (pcnt == last) begin
                     lcnt    <= '0;
                     addr_in <= '0;
                     prog_en <= 1'b0;
                     state   <= VSET;
                  end else begin
                     pcnt      <= pcnt + 22'd1;
                     prog_addr <= pcnt + 22'd1;
                     ref_in    <= pattern(pcnt + 22'd1);
                  end
               end
            end
            VSET: begin
               // shuffle registers addr_in this cycle
               if (stop) state <= DONE;
               else      state <= VREQ;
            end
            VREQ: begin
               if (!mem_req) begin
                  if (stop) begin
                     state <= DONE;
                  end else if (shf_addr > last) begin
                     state <= VNEXT;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= shf_addr;
                  end
               end else if (mem_ack) begin
                  mem_req   <= 1'b0;
                  dok_seen  <= mem_dok;
                  rd_data   <= mem_dout;
                  prog_en   <= 1'b1;
                  prog_addr <= mem_addr;
                  ref_in    <= pattern(mem_addr);
                  state     <= VWAIT;
               end
            end
            VWAIT: begin
               // ref_shf now carries the expected word for mem_addr
               if (dok_seen || mem_dok) begin
                  dok_seen <= 1'b0;
                  if (mismatch) begin
                     if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                     if (err_cnt == 16'd0)    err_addr <= mem_addr;
                  end
                  prog_en <= 1'b0;
                  state   <= VNEXT;
               end
            end
            VNEXT: begin
               if (stop) begin
                  state <= DONE;
               end else if (lcnt == LOG_LAST) begin
                  pass_cnt <= pass_cnt + 5'd1;
                  if (key == LAST_KEY) begin
                     state <= DONE;
                  end else begin
                     key       <= key + 5'd1;
                     pcnt      <= '0;
                     prog_en   <= 1'b1;
                     prog_addr <= '0;
                     ref_in    <= pattern(22'd0);
                     state     <= PROG;
                  end
               end else begin
                  lcnt    <= lcnt + 22'd1;
                  addr_in <= lcnt + 22'd1;
                  state   <= VSET;
               end
            end
            DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               prog_en <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtsdram_shuffle_seq.sv
// tb/tb_jtsdram_shuffle_seq.sv - bench for jtsdram_shuffle_seq with shuffle and SDRAM models
module tb_jtsdram_shuffle_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop;
   logic [21:0] addr_last;
   logic [4:0]  key;
   logic [21:0] addr_in;
   logic        prog_en;
   logic [21:0] prog_addr;
   logic [15:0] ref_in;
   logic [21:0] shf_addr;
   logic [15:0] ref_shf;
   logic        mem_req, mem_we;
   logic [21:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_ack, mem_dok;
   logic [15:0] mem_dout;
   logic        busy, done;
   logic [15:0] err_cnt;
   logic [21:0] err_addr;
   logic [4:0]  pass_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jtsdram_shuffle_seq #(.LAST_KEY(5'd3), .SEED(16'h5AC3), .LOG_LAST(22'd63)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .addr_last(addr_last),
      .key(key), .addr_in(addr_in), .prog_en(prog_en), .prog_addr(prog_addr),
      .ref_in(ref_in), .shf_addr(shf_addr), .ref_shf(ref_shf),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_ack(mem_ack), .mem_dok(mem_dok), .mem_dout(mem_dout),
      .busy(busy), .done(done), .err_cnt(err_cnt), .err_addr(err_addr), .pass_cnt(pass_cnt)
   );

   // shuffle model: registered permutation of the low 6 address bits, combinational data scramble
   always @(posedge clk or negedge rst_n)
      if (!rst_n) shf_addr <= '0;
      else        shf_addr <= {addr_in[21:6], addr_in[5:0] ^ {key, key[0]}};
   assign ref_shf = prog_en ? (ref_in ^ {key, 11'd0} ^ {prog_addr[5:0], 10'd0}) : 16'h0;

   // SDRAM model with programmable ack / data latency and an optional stuck-at-1 bit 0 at address 5
   int          ack_dly = 2;
   int          dok_dly = 1;
   bit          stuck = 1'b0;
   logic [15:0] mem [0:63];
   logic [1:0]  ph;
   int          cnt, dcnt;
   logic [21:0] radr;

   function automatic logic [15:0] rd(input logic [21:0] a);
      logic [15:0] d;
      d = mem[a[5:0]];
      if (stuck && a == 22'd5) d[0] = 1'b1;
      return d;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph <= 2'd0; cnt <= 0; dcnt <= -1; radr <= '0;
         mem_ack <= 1'b0; mem_dok <= 1'b0; mem_dout <= '0;
      end else begin
         mem_ack <= 1'b0;
         mem_dok <= 1'b0;
         if (dcnt == 0) begin mem_dok <= 1'b1; mem_dout <= rd(radr); end
         if (dcnt >= 0) dcnt <= dcnt - 1;
         case (ph)
            2'd0: if (mem_req) begin cnt <= 1; ph <= 2'd1; end
            2'd1: begin
               if (cnt >= ack_dly) begin
                  mem_ack <= 1'b1;
                  ph <= 2'd2;
                  if (mem_we) mem[mem_addr[5:0]] <= mem_din;
                  else begin
                     radr <= mem_addr;
                     if (dok_dly == 0) begin mem_dok <= 1'b1; mem_dout <= rd(mem_addr); end
                     else dcnt <= dok_dly - 1;
                  end
               end else cnt <= cnt + 1;
            end
            default: ph <= 2'd0;
         endcase
      end
   end

   // bus monitor: transaction counts and protocol rules
   int          n_wr = 0, n_rd = 0, n_oob = 0, n_unstable = 0, n_keychg = 0;
   logic [21:0] cur_last = '0;
   logic        prev_req = 1'b0;
   logic [38:0] prev_bus = '0;
   logic [4:0]  prev_key = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req && mem_ack) begin
            if (mem_we) n_wr++;
            else begin
               n_rd++;
               if (mem_addr > cur_last) n_oob++;
            end
         end
         if (mem_req && prev_req && {mem_we, mem_addr, mem_din} != prev_bus) n_unstable++;
         if (mem_req && prev_req && key != prev_key) n_keychg++;
      end
      prev_req = mem_req;
      prev_bus = {mem_we, mem_addr, mem_din};
      prev_key = key;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   typedef struct {
      logic [21:0] addr_last;
      bit          stuck;
      int          ack_dly;
      int          dok_dly;
      int          exp_err;
      int          exp_err_addr;
      int          exp_pass;
      int          exp_wr;
      int          exp_rd;
   } vec_t;

   task automatic run_vec(input string tag, input vec_t v);
      int w0, r0;
      bit ok;
      ack_dly = v.ack_dly; dok_dly = v.dok_dly; stuck = v.stuck;
      cur_last = v.addr_last; addr_last = v.addr_last;
      w0 = n_wr; r0 = n_rd;
      pulse_start();
      chk({tag, "_busy"}, busy, 1);
      wait_done(ok);
      chk({tag, "_done_seen"}, ok, 1);
      chk({tag, "_err_cnt"}, err_cnt, v.exp_err);
      chk({tag, "_err_addr"}, err_addr, v.exp_err_addr);
      chk({tag, "_pass_cnt"}, pass_cnt, v.exp_pass);
      chk({tag, "_writes"}, n_wr - w0, v.exp_wr);
      chk({tag, "_reads"}, n_rd - r0, v.exp_rd);
      chk({tag, "_key_final"}, key, 3);
      chk({tag, "_busy_end"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, done, 0);
   endtask

   vec_t vecs[5];
   bit   ok;

   initial begin
      //             last  stk ack dok err eaddr pass  wr   rd
      vecs[0] = '{22'd15, 1'b0, 2, 1, 0, 0, 4,  64,  64};
      vecs[1] = '{22'd15, 1'b1, 2, 1, 4, 5, 4,  64,  64};
      vecs[2] = '{22'd63, 1'b0, 1, 0, 0, 0, 4, 256, 256};
      vecs[3] = '{22'd0,  1'b1, 2, 3, 0, 0, 4,   4,   4};
      vecs[4] = '{22'd4,  1'b1, 3, 2, 0, 0, 4,  20,  20};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; addr_last = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs_zero",
          {key, addr_in, prog_en, prog_addr, ref_in, mem_req, mem_we, mem_addr, mem_din,
           busy, done, err_cnt, err_addr, pass_cnt} != 0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // start together with stop in IDLE is ignored
      @(negedge clk); start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b0;
      chk("start_stop_ignored", busy, 0);
      @(negedge clk);
      chk("start_stop_ignored_2", busy, 0);

      // stop during a slow write: request held until ack, then abort
      begin
         int w0;
         ack_dly = 10; dok_dly = 1; stuck = 1'b0; addr_last = 22'd15; cur_last = 22'd15;
         w0 = n_wr;
         pulse_start();
         ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            @(negedge clk);
         end
         chk("stop_req_seen", ok, 1);
         repeat (3) @(negedge clk);
         chk("stop_req_held", mem_req, 1);
         stop = 1'b1;
         wait_done(ok);
         stop = 1'b0;
         chk("stop_done_seen", ok, 1);
         chk("stop_writes", n_wr - w0, 1);
         chk("stop_pass_cnt", pass_cnt, 0);
         chk("stop_busy", busy, 0);
         chk("stop_mem_req", mem_req, 0);
      end

      // asynchronous reset while waiting for read data, then a clean rerun
      ack_dly = 2; dok_dly = 3; stuck = 1'b0; addr_last = 22'd15; cur_last = 22'd15;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (mem_req && mem_ack && !mem_we) begin ok = 1'b1; break; end
      end
      chk("rst_read_ack_seen", ok, 1);
      @(negedge clk);
      chk("rst_in_vwait", {mem_req, prog_en, busy}, 3'b011);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_zero",
          {key, addr_in, prog_en, prog_addr, ref_in, mem_req, mem_we, mem_addr, mem_din,
           busy, done, err_cnt, err_addr, pass_cnt} != 0, 0);
      @(negedge clk);
      chk("rst_no_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec("rerun", vecs[0]);

      chk("bus_stable_under_req", n_unstable, 0);
      chk("key_stable_under_req", n_keychg, 0);
      chk("no_read_beyond_last", n_oob, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
